fib_seq_gen: RTL and testbench
==============================

FIB_SEQ_GEN -- requirements
Module: fib_seq_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the term width in bits.
REQ-002 SHALL have parameter CNT_W, default 8, giving the term-count width in bits.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1 bit: request a new sequence; sampled only in IDLE.
REQ-006 SHALL have port mode, input, 1 bit: 0 = wrap modulo 2^WIDTH, 1 = saturate at 2^WIDTH-1; latched at start.
REQ-007 SHALL have port a0, input, WIDTH bits: seed term T0; latched at start.
REQ-008 SHALL have port a1, input, WIDTH bits: seed term T1; latched at start.
REQ-009 SHALL have port n, input, CNT_W bits: number of terms to emit; latched at start.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a valid term.
REQ-012 SHALL have port out_data, output, WIDTH bits: current term.
REQ-013 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse after the last term is transferred.
REQ-015 SHALL have port ovf, output, 1 bit: sticky flag, set when any emitted term overflowed.

Function
REQ-016 SHALL implement an FSM with states IDLE, RUN and FIN.
REQ-017 SHALL, in IDLE with start=1 at a clock edge, latch a0, a1, n and mode, clear ovf, and go to RUN if n>0 or to FIN if n=0.
REQ-018 SHALL ignore start in RUN and FIN; latched operands SHALL NOT change while busy.
REQ-019 SHALL assert out_valid in every RUN cycle and only in RUN; out_valid SHALL NOT depend combinationally on out_ready.
REQ-020 SHALL present T0=a0 on out_data in the first RUN cycle, i.e. one cycle after start is accepted.
REQ-021 SHALL emit terms in the order T0=a0, T1=a1, Tk=Tk-2+Tk-1 for k>=2.
REQ-022 SHALL advance to the next term only on a transfer (out_valid & out_ready); out_data and the internal state SHALL hold while out_ready=0.
REQ-023 SHALL count transfers; after the n-th transfer, the next state SHALL be FIN.
REQ-024 SHALL, with mode=0, compute Tk as the WIDTH-bit truncated sum; ovf SHALL be set when an emitted term's sum had a carry-out.
REQ-025 SHALL, with mode=1, emit 2^WIDTH-1 for any sum that carries out, set ovf, and keep all later terms at 2^WIDTH-1.
REQ-026 SHALL assert done for exactly one cycle in FIN, then return to IDLE; busy SHALL be high in RUN and FIN.
REQ-027 SHALL treat n=2^CNT_W-1 as the maximum count, with no wrap of the transfer counter.
REQ-028 SHALL never set ovf for the seed terms T0 or T1.
REQ-029 SHALL compute each term from the two preceding emitted values, independently of mode, except for the clamping described in REQ-025.

Reset
REQ-030 SHALL, while rst=0, immediately force state to IDLE and out_valid, busy, done and ovf to 0, and out_data and all internal registers to 0.
REQ-031 SHALL, if reset is asserted mid-sequence, abandon the sequence; after release no term and no done pulse from it SHALL appear.
REQ-032 SHALL accept a new start on the first rising edge after rst returns to 1.

Verification
REQ-033 SHALL pass this test: WIDTH=32, a0=0, a1=1, n=10, mode=0, out_ready=1 -> 0,1,1,2,3,5,8,13,21,34 on 10 consecutive cycles, done one cycle after 34, ovf=0.
REQ-034 SHALL pass this test: same sequence with out_ready toggled 1,0,0,1,... -> identical term order, out_data held during stalls, exactly 10 transfers, a single done pulse.
REQ-035 SHALL pass this test: WIDTH=8, a0=0, a1=1, n=16, mode=0 -> term 13=233, term 14=121, term 15=98, ovf=1 from the cycle after term 14 is transferred.
REQ-036 SHALL pass this test: WIDTH=8, same seeds, mode=1 -> term 13=233, terms 14 and 15 =255, ovf=1.
REQ-037 SHALL pass this test: n=0 with start -> no out_valid, busy=1 and done=1 in the single following cycle, then IDLE.
REQ-038 SHALL pass this test: rst pulled low after 3 transfers of the REQ-033 run -> outputs 0 immediately, no done; after release, a new start with a0=2, a1=1, n=4 -> 2,1,3,4.

Source files
------------

// File: rtl/fib_seq_gen_if.sv
// fib_seq_gen_if: request/operand inputs and valid/ready term stream of the Fibonacci generator
interface fib_seq_gen_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] a1;
    logic [CNT_W-1:0] n;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             busy;
    logic             done;
    logic             ovf;
    modport master (
        output start, mode, a0, a1, n, out_ready,
        input  out_valid, out_data, busy, done, ovf
    );
    modport slave (
        input  start, mode, a0, a1, n, out_ready,
        output out_valid, out_data, busy, done, ovf
    );
endinterface

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: emits n Fibonacci-style terms from two seeds over valid/ready, wrapping or saturating
module fib_seq_gen #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input logic          clk,
    input logic          rst,
    fib_seq_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t           state;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] nxt;
    logic             cur_c;
    logic             nxt_c;
    logic             sat_mode;
    logic [CNT_W-1:0] cnt;
    logic             valid;
    logic             busy;
    logic             done;
    logic             ovf;
    logic [WIDTH:0]   sum;
    // sum of the two most recent terms; the top bit is the carry-out
    always_comb sum = {1'b0, cur} + {1'b0, nxt};
    // sequencer: cur is the term on display, nxt the one after it; each carries its own overflow flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur      <= '0;
            nxt      <= '0;
            cur_c    <= 1'b0;
            nxt_c    <= 1'b0;
            sat_mode <= 1'b0;
            cnt      <= '0;
            valid    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    cur      <= bus.a0;
                    nxt      <= bus.a1;
                    cur_c    <= 1'b0;
                    nxt_c    <= 1'b0;
                    sat_mode <= bus.mode;
                    cnt      <= bus.n;
                    ovf      <= 1'b0;
                    busy     <= 1'b1;
                    state    <= (bus.n != '0) ? RUN : FIN;
                    valid    <= (bus.n != '0);
                    done     <= (bus.n == '0);
                end
                RUN: if (bus.out_ready) begin
                    cur   <= nxt;
                    cur_c <= nxt_c;
                    nxt   <= (sat_mode && sum[WIDTH]) ? '1 : sum[WIDTH-1:0];
                    nxt_c <= sum[WIDTH];
                    ovf   <= ovf | cur_c;
                    cnt   <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= FIN;
                        valid <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.out_valid = valid;
    assign bus.out_data  = cur;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.ovf       = ovf;
endmodule

// File: tb/tb_fib_seq_gen.sv
// tb_fib_seq_gen: random and directed checks of a 32-bit and an 8-bit generator against a term-list model
module tb_fib_seq_gen;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fib_seq_gen_if #(.WIDTH(32), .CNT_W(8)) if0 ();
    fib_seq_gen_if #(.WIDTH(8), .CNT_W(8))  if1 ();
    fib_seq_gen #(.WIDTH(32), .CNT_W(8)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    fib_seq_gen #(.WIDTH(8), .CNT_W(8))  dut1 (.clk(clk), .rst(rst), .bus(if1));

    logic        start [2];
    logic        md    [2];
    logic        ready [2];
    logic [63:0] a0v   [2];
    logic [63:0] a1v   [2];
    logic [7:0]  nv    [2];
    logic        dv    [2];
    logic        dbusy [2];
    logic        ddone [2];
    logic        dovf  [2];
    logic [63:0] dd    [2];

    assign if0.start = start[0];
    assign if0.mode = md[0];
    assign if0.a0 = a0v[0][31:0];
    assign if0.a1 = a1v[0][31:0];
    assign if0.n = nv[0];
    assign if0.out_ready = ready[0];
    assign if1.start = start[1];
    assign if1.mode = md[1];
    assign if1.a0 = a0v[1][7:0];
    assign if1.a1 = a1v[1][7:0];
    assign if1.n = nv[1];
    assign if1.out_ready = ready[1];
    assign dv[0] = if0.out_valid;
    assign dd[0] = {32'b0, if0.out_data};
    assign dbusy[0] = if0.busy;
    assign ddone[0] = if0.done;
    assign dovf[0] = if0.ovf;
    assign dv[1] = if1.out_valid;
    assign dd[1] = {56'b0, if1.out_data};
    assign dbusy[1] = if1.busy;
    assign ddone[1] = if1.done;
    assign dovf[1] = if1.ovf;

    // model: full expected term list per sequence plus a phase (0 idle, 1 emitting, 2 finishing)
    logic [63:0] et [2][256];
    bit          ec [2][256];
    int          m_ph [2];
    int          m_k  [2];
    int          m_n  [2];
    bit          m_ovf [2];
    logic [63:0] lg [2][300];
    int          lgn [2];
    int          dcnt [2];
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic void gen(input int d, input logic [63:0] x0, input logic [63:0] x1, input bit sat);
        logic [63:0] mx;
        logic [63:0] s;
        mx = (d == 0) ? 64'hFFFF_FFFF : 64'hFF;
        et[d][0] = x0 & mx;
        et[d][1] = x1 & mx;
        ec[d][0] = 1'b0;
        ec[d][1] = 1'b0;
        for (int k = 2; k < 256; k++) begin
            s = et[d][k-2] + et[d][k-1];
            ec[d][k] = (s > mx);
            et[d][k] = (s > mx) ? (sat ? mx : s - mx - 64'd1) : s;
        end
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                m_ph[d] = 0;
                m_k[d] = 0;
                m_ovf[d] = 1'b0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (m_ph[d] == 0) begin
                    if (start[d]) begin
                        gen(d, a0v[d], a1v[d], md[d]);
                        m_n[d] = int'(nv[d]);
                        m_k[d] = 0;
                        m_ovf[d] = 1'b0;
                        m_ph[d] = (nv[d] != 8'd0) ? 1 : 2;
                    end
                end else if (m_ph[d] == 1) begin
                    if (ready[d]) begin
                        m_ovf[d] = m_ovf[d] | ec[d][m_k[d]];
                        m_k[d]++;
                        if (m_k[d] == m_n[d]) m_ph[d] = 2;
                    end
                end else m_ph[d] = 0;
            end
        end
    end

    // compare every cycle on the falling edge and log each transfer
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("valid%0d", d), {63'b0, dv[d]}, {63'b0, m_ph[d] == 1});
            chk($sformatf("busy%0d", d), {63'b0, dbusy[d]}, {63'b0, m_ph[d] != 0});
            chk($sformatf("done%0d", d), {63'b0, ddone[d]}, {63'b0, m_ph[d] == 2});
            chk($sformatf("ovf%0d", d), {63'b0, dovf[d]}, {63'b0, m_ovf[d]});
            if (m_ph[d] == 1) chk($sformatf("data%0d_t%0d", d, m_k[d]), dd[d], et[d][m_k[d]]);
            if (dv[d] && ready[d] && lgn[d] < 300) begin
                lg[d][lgn[d]] = dd[d];
                lgn[d]++;
            end
            if (ddone[d]) dcnt[d]++;
        end
    end

    // runs one sequence; rp selects out_ready: 0 always high, 1 the 1,0,0 pattern, 2 random with stray starts
    task automatic seq(input int d, input logic [63:0] x0, input logic [63:0] x1, input int cnt, input bit sat, input int rp);
        int j = 0;
        lgn[d] = 0;
        dcnt[d] = 0;
        start[d] = 1'b1;
        a0v[d] = x0;
        a1v[d] = x1;
        nv[d] = 8'(cnt);
        md[d] = sat;
        ready[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
        a0v[d] = {$urandom, $urandom};
        a1v[d] = {$urandom, $urandom};
        nv[d] = 8'($urandom);
        md[d] = 1'($urandom);
        while (dbusy[d] && j < 2000) begin
            ready[d] = (rp == 0) ? 1'b1 : (rp == 1) ? (j % 3 == 0) : ($urandom % 3 != 0);
            if (rp == 2) start[d] = ($urandom % 4 == 0);
            j++;
            @(posedge clk); #1;
        end
        start[d] = 1'b0;
        chk("seq_end_busy", {63'b0, dbusy[d]}, 64'd0);
    endtask

    logic [63:0] fib10 [10];
    logic [63:0] tail [4];

    initial begin
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            md[d] = 1'b0;
            ready[d] = 1'b0;
            a0v[d] = '0;
            a1v[d] = '0;
            nv[d] = '0;
            lgn[d] = 0;
            dcnt[d] = 0;
        end
        fib10 = '{64'd0, 64'd1, 64'd1, 64'd2, 64'd3, 64'd5, 64'd8, 64'd13, 64'd21, 64'd34};
        tail = '{64'd2, 64'd1, 64'd3, 64'd4};
        #12;
        chk("rst_data0", dd[0], 64'd0);
        chk("rst_data1", dd[1], 64'd0);
        chk("rst_valid0", {63'b0, dv[0]}, 64'd0);
        chk("rst_busy0", {63'b0, dbusy[0]}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        seq(0, 64'd0, 64'd1, 10, 1'b0, 0);
        for (int i = 0; i < 10; i++) chk($sformatf("fib_term%0d", i), lg[0][i], fib10[i]);
        chk("fib_transfers", 64'(lgn[0]), 64'd10);
        chk("fib_done_pulses", 64'(dcnt[0]), 64'd1);
        chk("fib_ovf", {63'b0, dovf[0]}, 64'd0);

        seq(0, 64'd0, 64'd1, 10, 1'b0, 1);
        for (int i = 0; i < 10; i++) chk($sformatf("stall_term%0d", i), lg[0][i], fib10[i]);
        chk("stall_transfers", 64'(lgn[0]), 64'd10);
        chk("stall_done_pulses", 64'(dcnt[0]), 64'd1);

        seq(1, 64'd0, 64'd1, 16, 1'b0, 0);
        chk("model_wrap_t14", et[1][14], 64'd121);
        chk("wrap_t13", lg[1][13], 64'd233);
        chk("wrap_t14", lg[1][14], 64'd121);
        chk("wrap_t15", lg[1][15], 64'd98);
        chk("wrap_ovf", {63'b0, dovf[1]}, 64'd1);

        seq(1, 64'd0, 64'd1, 16, 1'b1, 0);
        chk("model_sat_t15", et[1][15], 64'd255);
        chk("sat_t13", lg[1][13], 64'd233);
        chk("sat_t14", lg[1][14], 64'd255);
        chk("sat_t15", lg[1][15], 64'd255);
        chk("sat_ovf", {63'b0, dovf[1]}, 64'd1);

        lgn[0] = 0;
        dcnt[0] = 0;
        start[0] = 1'b1;
        nv[0] = 8'd0;
        @(posedge clk); #1;
        start[0] = 1'b0;
        chk("n0_valid", {63'b0, dv[0]}, 64'd0);
        chk("n0_busy", {63'b0, dbusy[0]}, 64'd1);
        chk("n0_done", {63'b0, ddone[0]}, 64'd1);
        @(posedge clk); #1;
        chk("n0_idle_busy", {63'b0, dbusy[0]}, 64'd0);
        chk("n0_idle_done", {63'b0, ddone[0]}, 64'd0);
        chk("n0_transfers", 64'(lgn[0]), 64'd0);

        start[0] = 1'b1;
        a0v[0] = 64'd0;
        a1v[0] = 64'd1;
        nv[0] = 8'd10;
        md[0] = 1'b0;
        ready[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("abort_data", dd[0], 64'd0);
        chk("abort_valid", {63'b0, dv[0]}, 64'd0);
        chk("abort_busy", {63'b0, dbusy[0]}, 64'd0);
        chk("abort_done", {63'b0, ddone[0]}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        seq(0, 64'd2, 64'd1, 4, 1'b0, 0);
        for (int i = 0; i < 4; i++) chk($sformatf("restart_term%0d", i), lg[0][i], tail[i]);
        chk("restart_transfers", 64'(lgn[0]), 64'd4);
        chk("restart_done_pulses", 64'(dcnt[0]), 64'd1);

        repeat (40) begin
            int d;
            int cnt;
            d = int'($urandom % 2);
            cnt = ($urandom % 10 == 0) ? 255 : int'($urandom % 14);
            seq(d, (d == 0 || $urandom % 2 == 0) ? {32'b0, $urandom} : 64'($urandom % 8),
                {32'b0, $urandom}, cnt, 1'($urandom), 2);
            chk($sformatf("rand_transfers%0d", d), 64'(lgn[d]), 64'(cnt));
            chk($sformatf("rand_done%0d", d), 64'(dcnt[d]), 64'd1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end
endmodule
